autoencoder_sequencer: RTL
==========================

# autoencoder_sequencer

Instruction sequencer for the autoencoder datapath: holds the program in an internal instruction memory, fetches 16-bit instructions (opcode, field 1, field 2, field 3; 4 bits each) and presents them to the CU and sector selectors with correctly timed enables. It executes loop and halt control opcodes itself and runs a start/busy/done handshake with the host. It sits between the host/testbench and the existing CU, sel_mem, ALU and memory datapath.

## Interface
- PROG_DEPTH, 256, number of instruction words in program memory
- ADDR_W, 8, program counter width; requires 2**ADDR_W == PROG_DEPTH
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution at pc=0; honoured only in IDLE
- abort  in  1  synchronous stop; returns to IDLE next edge, no done
- prog_we  in  1  program memory write strobe; honoured only in IDLE
- prog_addr  in  ADDR_W  program memory write address
- prog_data  in  16  program word to write
- instruction  out  16  current instruction to CU/sel_mem (opcode = [15:12])
- enable_sel_mem  out  1  one-cycle strobe; sel_mem latches the instruction fields
- instr_valid  out  1  EXEC cycle; CU enables are meaningful, writeback at end of cycle
- pc  out  ADDR_W  address of the current instruction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on HALT completion
- pc_overflow  out  1  sticky; set on pc wrap without HALT, cleared by start or reset

## Operation
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- Opcodes 0x0–0xD are datapath ops and pass through to the CU. 0xE is LOOP. 0xF is HALT.
- IDLE:
  - prog_we writes mem[prog_addr] = prog_data.
  - start: pc=0, loop_cnt=0, pc_overflow=0, next state FETCH.
- FETCH: instruction <= mem[pc] (synchronous read into the output register); next state DECODE.
- DECODE, datapath op: enable_sel_mem=1; next state EXEC.
- DECODE, LOOP (target = instruction[11:4], N = instruction[3:0]):
  - loop_cnt==0 and N!=0: loop_cnt=N, pc=target.
  - loop_cnt!=0: loop_cnt=loop_cnt-1; pc=target if the decremented value is !=0, else pc=pc+1.
  - N==0 with loop_cnt==0: pc=pc+1 (no-op).
  - Next state FETCH. No enable_sel_mem, no instr_valid.
  - Net effect: loop body executes N+1 times. Single level only; nested LOOPs share loop_cnt and behaviour is undefined.
- DECODE, HALT: next state DONE. No enables.
- EXEC: instr_valid=1; pc=pc+1 at end of cycle; next state FETCH.
- DONE: done=1 for one cycle; next state IDLE.
- pc wrap: an increment from PROG_DEPTH-1 gives 0 and sets pc_overflow; execution continues.
- Only control ops move pc backwards; datapath ops never stall.

## Timing
- Reset values: state IDLE, instruction=16'h0000, pc=0, loop_cnt=0, enable_sel_mem=0, instr_valid=0, busy=0, done=0, pc_overflow=0. Program memory contents are not reset.
- start high at edge k: busy=1 from cycle k+1, which is FETCH.
- Datapath instruction: 3 cycles (FETCH, DECODE, EXEC).
  - instruction is stable from DECODE through EXEC.
  - enable_sel_mem is high exactly in DECODE, so sel_mem outputs are valid in EXEC.
- LOOP: 2 cycles. HALT: 2 cycles plus the DONE cycle.
- done and busy are both high in the DONE cycle; busy=0 the cycle after.
- Ignored inputs: start while busy; prog_we while busy.
- start and prog_we high in the same IDLE cycle: the write lands at that edge, and the first FETCH reads the updated memory.
- abort beats every transition, including HALT in DECODE: next state IDLE, done stays 0, pc and pc_overflow hold their values.
- reset mid-run: all outputs return to reset values at that edge.

## Test plan
- Straight-line program: mem = {0x1123, 0x2456, 0xF000}, then start.
  - enable_sel_mem pulses 2 times, instr_valid pulses 2 times.
  - instruction = 0x1123 then 0x2456.
  - done pulses at cycle 9 after start; busy falls at cycle 10.
- Loop: mem = {0x1000, 0xE003, 0xF000}.
  - The 0x1000 EXEC occurs 4 times, LOOP decodes 4 times, then done.
  - Total 4×3 + 4×2 + 3 = 23 cycles.
- LOOP with N=0 (0xE000): falls through; body executes once.
- Writes while busy: prog_we and start asserted mid-run are ignored. Read back by a rerun that shows unchanged instructions.
- abort during EXEC of instruction 1: IDLE next cycle, done never pulses, pc holds 1. A subsequent start restarts at pc=0.
- No HALT with PROG_DEPTH=4: pc wraps 3→0 and pc_overflow=1 stays set. A new start clears it. A reset asserted mid-FETCH gives all outputs 0 next cycle.

Source files
------------

// File: rtl/autoencoder_sequencer.sv
// Instruction sequencer for the autoencoder datapath: owns the program memory,
// walks it FETCH/DECODE/EXEC, runs LOOP/HALT itself and handshakes with the host.
module autoencoder_sequencer #(
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       instruction,
  output logic              enable_sel_mem,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              pc_overflow
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0]        OP_LOOP = 4'hE;
  localparam logic [3:0]        OP_HALT = 4'hF;
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        loop_cnt_q, loop_cnt_d;
  logic [15:0]       instr_q, instr_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       mem_q [PROG_DEPTH];

  logic [3:0]        opcode;
  logic [3:0]        loop_n;
  logic [3:0]        loop_dec;
  logic [ADDR_W-1:0] loop_target;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_wraps;

  assign opcode      = instr_q[15:12];
  assign loop_n      = instr_q[3:0];
  assign loop_target = ADDR_W'(instr_q[11:4]);
  assign loop_dec    = loop_cnt_q - 4'd1;
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign pc_wraps    = (pc_q == PC_LAST);

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clock) begin
    if (prog_we && (state_q == IDLE)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      loop_cnt_q <= '0;
      instr_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      instr_q    <= instr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    instr_d    = instr_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          pc_d       = '0;
          loop_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      FETCH: begin
        instr_d = mem_q[pc_q];
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = DONE;
        end else if (opcode == OP_LOOP) begin
          state_d = FETCH;
          // A running count is consumed first; a fresh LOOP only arms when N is non-zero.
          if (loop_cnt_q != 4'd0) begin
            loop_cnt_d = loop_dec;
            if (loop_dec != 4'd0) begin
              pc_d = loop_target;
            end else begin
              pc_d  = pc_inc;
              ovf_d = ovf_q | pc_wraps;
            end
          end else if (loop_n != 4'd0) begin
            loop_cnt_d = loop_n;
            pc_d       = loop_target;
          end else begin
            pc_d  = pc_inc;
            ovf_d = ovf_q | pc_wraps;
          end
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        ovf_d   = ovf_q | pc_wraps;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort freezes every register except the state, even a pending HALT.
    if (abort) begin
      state_d    = IDLE;
      pc_d       = pc_q;
      loop_cnt_d = loop_cnt_q;
      instr_d    = instr_q;
      ovf_d      = ovf_q;
    end
  end

  always_comb begin
    enable_sel_mem = 1'b0;
    instr_valid    = 1'b0;
    done           = 1'b0;
    busy           = (state_q != IDLE);
    case (state_q)
      DECODE:  enable_sel_mem = (opcode != OP_LOOP) && (opcode != OP_HALT);
      EXEC:    instr_valid = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc_overflow = ovf_q;

endmodule
